id_stage_ctrl: RTL
==================

// Module: id_stage_ctrl
// PURPOSE
//  Decode stage directly downstream of the IF/ID register. Decodes the SPARC word held in IF/ID,
//  resolves Bicc/CALL/JMPL (drives IF next-PC select, target address, IF/ID annul clear),
//  detects load-use hazards and stalls IF, and registers decoded fields into the ID/EX register.
// PARAMETERS
//  STALL_CYCLES  1  bubbles inserted per load-use hazard (legal 1..3)
//  DCTI_CHECK    1  1 = CTI in a delay slot is squashed and flags dcti_err; 0 = no check
// PORTS
//  clk          in   1   clock, all state on rising edge
//  R            in   1   reset, asynchronous, active-low
//  instr_in     in   32  instruction from IF/ID
//  pc_in        in   32  PC of instr_in from IF/ID
//  icc          in   4   {N,Z,V,C}, already forwarded, valid this cycle
//  ex_load      in   1   instruction currently in EX is a load
//  ex_rd        in   5   destination register of EX instruction
//  pc_sel       out  2   IF mux select: 00 nPC, 01 ta, 10 alu_out (JMPL)
//  ta           out  32  branch/call target
//  if_le        out  1   load enable for PC, nPC and IF/ID (0 = stall)
//  ch_clear     out  1   clear IF/ID next edge (annul delay slot)
//  dcti_err     out  1   sticky: CTI found in a delay slot
//  idex_valid   out  1   ID/EX holds a real instruction
//  idex_pc      out  32  registered pc_in
//  idex_rs1/idex_rs2/idex_rd  out  5 each  register fields
//  idex_simm    out  32  sext(instr[12:0]), or {instr[21:0],10'b0} for SETHI
//  idex_op3     out  6   instr[24:19]
//  idex_use_imm out  1   instr[13] for op=10/11; 1 for SETHI
//  idex_load/idex_store/idex_we  out  1 each  load, store, register write-back
// BEHAVIOUR
//  Reset (R=0, any time, immediate): all idex_* = 0, dcti_err=0, stall count=0, FSM=RUN,
//   ds_flag=0. While R=0: if_le=0, pc_sel=00, ch_clear=0, ta=0.
//  Decode: op=instr[31:30]. 01 CALL: rd=15, we=1, ta=pc_in+{disp30,2'b00}, pc_sel=01.
//   00/op2=010 Bicc: cond=instr[28:25], a=instr[29], ta=pc_in+(sext(disp22)<<2).
//   00/op2=100 SETHI: we=1. 10: ALU, we=1 unless rd=0; op3=111000 JMPL: pc_sel=10, we=1.
//   11: memory; op3[2]=1 store (we=0), else load (we=1). 32'h0 and other op2 = NOP, valid=0.
//  Adds wrap mod 2^32. Condition table (SPARC V8): 0000 never, 1000 always, 0001 Z,
//   0010 Z|(N^V), 0011 N^V, 0100 C|Z, 0101 C, 0110 N, 0111 V; cond[3]=1 negates 0001-0111.
//  Taken Bicc: pc_sel=01. Not taken: pc_sel=00. Outputs combinational, same cycle.
//  Annul: ch_clear=1 when a=1 and (not taken, or cond=1000). Delay-slot word is cleared to NOP.
//  Hazard: rs1 match always; rs2 only if i=0; rd only for stores. Hazard when ex_load=1,
//   ex_rd!=0, and ex_rd matches a used source.
//  FSM RUN/STALL: hazard in RUN -> STALL, count=STALL_CYCLES-1.
//   In STALL: if_le=0, pc_sel=00, ch_clear=0; ID/EX gets a bubble (valid=0, we/load/store=0).
//   STALL -> RUN when count=0, else count decrements. Hazard re-checked on return.
//   A CTI under stall resolves only after the stall.
//  RUN without hazard: if_le=1, ID/EX loads decoded fields each edge.
//  ds_flag set on the edge a CTI (CALL, Bicc, JMPL) leaves ID; cleared on next non-stall edge.
//   Cleared, not set, if ch_clear annulled the slot.
//   If DCTI_CHECK=1 and ds_flag=1 with a CTI in ID: pc_sel=00, ch_clear=0,
//    bubble into ID/EX, dcti_err<=1 (sticky until reset).
//  Simultaneous hazard + branch: stall wins; no redirect and no annul that cycle.
// TESTING
//  1. Reset R=0 mid-stall -> idex_* = 0, if_le=0 at once; R=1 -> RUN, if_le=1 next cycle.
//  2. Bicc BE, pc_in=0x40, disp22=-2, icc Z=1 -> pc_sel=01, ta=0x38, ch_clear=0.
//     Same with Z=0, a=1 -> pc_sel=00, ch_clear=1.
//  3. BA a=1, disp22=0x3FFFFF, pc_in=0 -> ta=0xFFFFFFFC (wrap), pc_sel=01, ch_clear=1.
//  4. ex_load=1, ex_rd=5, ID add r5 as rs1, STALL_CYCLES=2 -> if_le=0 for 2 cycles,
//     2 bubbles, add enters ID/EX on 3rd edge. Same with ex_rd=0 -> no stall.
//  5. CALL at pc_in=0x100, disp30=4 -> ta=0x110, idex_rd=15, idex_we=1;
//     JMPL in delay slot -> squashed, dcti_err=1 and stays 1.
//  6. Store st r7 with i=1, ex_load=1, ex_rd=7 -> stall (rd is a source);
//     ALU r3,imm with ex_rd=3 as rs2 field -> no stall.

Source files
------------

// File: rtl/id_stage_ctrl.sv
// SPARC decode stage: decodes the IF/ID word, resolves Bicc/CALL/JMPL, stalls IF on
// load-use hazards and registers the decoded fields into ID/EX.
module id_stage_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter bit DCTI_CHECK   = 1'b1
) (
    input  logic        clk,
    input  logic        R,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [3:0]  icc,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    output logic [1:0]  pc_sel,
    output logic [31:0] ta,
    output logic        if_le,
    output logic        ch_clear,
    output logic        dcti_err,
    output logic        idex_valid,
    output logic [31:0] idex_pc,
    output logic [4:0]  idex_rs1,
    output logic [4:0]  idex_rs2,
    output logic [4:0]  idex_rd,
    output logic [31:0] idex_simm,
    output logic [5:0]  idex_op3,
    output logic        idex_use_imm,
    output logic        idex_load,
    output logic        idex_store,
    output logic        idex_we,
    output logic        dbg_state,
    output logic        dbg_ds_flag
);

    typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] simm;
        logic [5:0]  op3;
        logic        use_imm;
        logic        load;
        logic        store;
        logic        we;
    } idex_t;

    // The hazard cycle itself is the first bubble; STALL supplies the remaining ones.
    localparam logic [1:0] LP_CNT_INIT = 2'((STALL_CYCLES > 1) ? (STALL_CYCLES - 2) : 0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic        r_ds_flag;
    logic        r_dcti_err;
    idex_t       r_idex;
    idex_t       w_idex_nxt;

    logic [1:0]  w_op;
    logic [2:0]  w_op2;
    logic [5:0]  w_op3;
    logic [4:0]  w_rd_f;
    logic [4:0]  w_rs1_f;
    logic [4:0]  w_rs2_f;
    logic        w_i;
    logic        w_a;
    logic [3:0]  w_cond;

    logic        w_valid;
    logic        w_is_call;
    logic        w_is_bicc;
    logic        w_is_jmpl;
    logic        w_we;
    logic        w_load;
    logic        w_store;
    logic        w_use_imm;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_use_rd;
    logic [4:0]  w_rd;
    logic [31:0] w_simm;

    logic        w_n, w_z, w_v, w_c;
    logic        w_base;
    logic        w_taken;
    logic [31:0] w_bicc_ta;
    logic [31:0] w_call_ta;

    logic        w_hazard;
    logic        w_cti;
    logic        w_dcti;
    logic        w_stall;
    logic        w_advance;
    logic        w_redirect_ok;
    logic        w_squash;
    logic        w_issue;
    logic        w_annul;
    logic [1:0]  w_pc_sel;

    assign w_op    = instr_in[31:30];
    assign w_op2   = instr_in[24:22];
    assign w_op3   = instr_in[24:19];
    assign w_rd_f  = instr_in[29:25];
    assign w_rs1_f = instr_in[18:14];
    assign w_rs2_f = instr_in[4:0];
    assign w_i     = instr_in[13];
    assign w_a     = instr_in[29];
    assign w_cond  = instr_in[28:25];

    always_comb begin
        w_valid   = 1'b0;
        w_is_call = 1'b0;
        w_is_bicc = 1'b0;
        w_is_jmpl = 1'b0;
        w_we      = 1'b0;
        w_load    = 1'b0;
        w_store   = 1'b0;
        w_use_imm = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_rd      = w_rd_f;
        w_simm    = {{19{instr_in[12]}}, instr_in[12:0]};
        case (w_op)
            2'b01: begin
                w_valid   = 1'b1;
                w_is_call = 1'b1;
                w_we      = 1'b1;
                w_rd      = 5'd15;
            end
            2'b00: begin
                if (w_op2 == 3'b010) begin
                    w_valid   = 1'b1;
                    w_is_bicc = 1'b1;
                end else if (w_op2 == 3'b100) begin
                    w_valid   = 1'b1;
                    w_we      = 1'b1;
                    w_use_imm = 1'b1;
                    w_simm    = {instr_in[21:0], 10'b0};
                end
            end
            2'b10: begin
                w_valid   = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = ~w_i;
                w_use_imm = w_i;
                if (w_op3 == 6'b111000) begin
                    w_is_jmpl = 1'b1;
                    w_we      = 1'b1;
                end else begin
                    w_we      = (w_rd_f != 5'd0);
                end
            end
            default: begin
                w_valid   = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = ~w_i;
                w_use_imm = w_i;
                if (w_op3[2]) begin
                    w_store  = 1'b1;
                    w_use_rd = 1'b1;
                end else begin
                    w_load   = 1'b1;
                    w_we     = 1'b1;
                end
            end
        endcase
    end

    assign {w_n, w_z, w_v, w_c} = icc;

    always_comb begin
        w_base = 1'b0;
        case (w_cond[2:0])
            3'b001:  w_base = w_z;
            3'b010:  w_base = w_z | (w_n ^ w_v);
            3'b011:  w_base = w_n ^ w_v;
            3'b100:  w_base = w_c | w_z;
            3'b101:  w_base = w_c;
            3'b110:  w_base = w_n;
            3'b111:  w_base = w_v;
            default: w_base = 1'b0;
        endcase
    end

    assign w_taken   = w_cond[3] ^ w_base;
    assign w_bicc_ta = pc_in + {{8{instr_in[21]}}, instr_in[21:0], 2'b00};
    assign w_call_ta = pc_in + {instr_in[29:0], 2'b00};

    assign w_hazard = ex_load && (ex_rd != 5'd0) &&
                      ((w_use_rs1 && (ex_rd == w_rs1_f)) ||
                       (w_use_rs2 && (ex_rd == w_rs2_f)) ||
                       (w_use_rd  && (ex_rd == w_rd_f)));

    assign w_cti  = w_is_call | w_is_bicc | w_is_jmpl;
    assign w_dcti = DCTI_CHECK && r_ds_flag && w_cti;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_hazard) begin
                    w_stall = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        w_state_nxt = ST_STALL;
                        w_cnt_nxt   = LP_CNT_INIT;
                    end
                end
            end
            ST_STALL: begin
                w_stall = 1'b1;
                if (r_cnt == 2'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt   = r_cnt - 2'd1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // if_le is the ready back to IF: the IF/ID word is consumed on an edge only when
    // if_le=1, and idex_valid=1 marks a real instruction sitting in ID/EX.
    assign w_advance     = ~w_stall;
    assign w_redirect_ok = w_advance & ~w_dcti;
    assign w_squash      = w_advance & w_dcti;
    assign w_issue       = w_redirect_ok & w_valid;
    assign w_annul       = w_redirect_ok & w_is_bicc & w_a & (~w_taken | (w_cond == 4'b1000));

    always_comb begin
        w_pc_sel = 2'b00;
        if (w_redirect_ok) begin
            if (w_is_call || (w_is_bicc && w_taken)) begin
                w_pc_sel = 2'b01;
            end else if (w_is_jmpl) begin
                w_pc_sel = 2'b10;
            end
        end
    end

    assign pc_sel   = R ? w_pc_sel : 2'b00;
    assign if_le    = R & w_advance;
    assign ch_clear = R & w_annul;
    assign ta       = !R        ? 32'h0 :
                      w_is_call ? w_call_ta :
                      w_is_bicc ? w_bicc_ta : 32'h0;

    assign w_idex_nxt = {1'b1, pc_in, w_rs1_f, w_rs2_f, w_rd, w_simm, w_op3,
                         w_use_imm, w_load, w_store, w_we};

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // An annulled slot never executes, so it is not treated as a delay slot.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_ds_flag  <= 1'b0;
            r_dcti_err <= 1'b0;
            r_idex     <= '0;
        end else begin
            if (w_advance) begin
                r_ds_flag <= w_cti & ~w_dcti & ~w_annul;
            end
            if (w_squash) begin
                r_dcti_err <= 1'b1;
            end
            if (w_issue) begin
                r_idex <= w_idex_nxt;
            end else begin
                r_idex <= '0;
            end
        end
    end

    assign dcti_err     = r_dcti_err;
    assign idex_valid   = r_idex.valid;
    assign idex_pc      = r_idex.pc;
    assign idex_rs1     = r_idex.rs1;
    assign idex_rs2     = r_idex.rs2;
    assign idex_rd      = r_idex.rd;
    assign idex_simm    = r_idex.simm;
    assign idex_op3     = r_idex.op3;
    assign idex_use_imm = r_idex.use_imm;
    assign idex_load    = r_idex.load;
    assign idex_store   = r_idex.store;
    assign idex_we      = r_idex.we;
    assign dbg_state    = (r_state == ST_STALL);
    assign dbg_ds_flag  = r_ds_flag;

endmodule
